regfile_gen: RTL and testbench

REGFILE_GEN -- requirements
Module: regfile_gen

---
 rtl/regfile_gen.sv | 159 +++++++++++++++
 tb/tb_regfile_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_gen.sv
`default_nettype none
// ============================================================================
// Module   : regfile_gen
// Purpose  : Two-read/one-write register file with optional hardwired zero
//            register, optional write-to-read bypass, a debug read port and a
//            self-timed clear sweep that also runs after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_gen #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            we3,
  input  logic            clr_req,
  input  logic [AW-1:0]   dbg_a,
  output logic [XLEN-1:0] dbg_rd,
  output logic            busy
);

  localparam logic [AW-1:0] PTR_LAST = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] rf_q [NREGS];

  logic            w_writable;
  logic            w_user_we;
  logic            w_rf_we;
  logic [AW-1:0]   w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;
  logic            w_hit1;
  logic            w_hit2;

  // ---------------------------------------------------------------------------
  // Clear-sweep control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Reset parks the FSM at the start of a sweep so storage is wiped on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  generate
    if (ZERO_REG != 0) begin : g_zero_wr
      assign w_writable = (a3 != '0);
    end else begin : g_plain_wr
      assign w_writable = 1'b1;
    end
  endgenerate

  assign w_user_we = we3 & ~busy_q & w_writable;

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = a3;
    w_rf_wdata = wd3;
    if (state_q == ST_CLEAR) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = ptr_q;
      w_rf_wdata = '0;
    end else if (w_user_we) begin
      w_rf_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_we) begin
      rf_q[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_hit1 = w_user_we & (a3 == a1);
      assign w_hit2 = w_user_we & (a3 == a2);
    end else begin : g_no_bypass
      assign w_hit1 = 1'b0;
      assign w_hit2 = 1'b0;
    end
  endgenerate

  function automatic logic [XLEN-1:0] rf_peek(input logic [AW-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end
    return rf_q[addr];
  endfunction

  // All reads are blanked during a sweep, including while held in reset.
  always_comb begin
    rd1    = '0;
    rd2    = '0;
    dbg_rd = '0;
    if (!busy_q) begin
      rd1    = w_hit1 ? wd3 : rf_peek(a1);
      rd2    = w_hit2 ? wd3 : rf_peek(a2);
      dbg_rd = rf_peek(dbg_a);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_gen
// Purpose  : Self-checking bench for regfile_gen (default build plus a
//            64-bit / 8-entry / no-bypass build) against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic [4:0]  a1_a, a2_a, a3_a, dbg_a_a;
  logic [31:0] wd3_a, rd1_a, rd2_a, dbg_rd_a;
  logic        we3_a, clr_a, busy_a;

  // 64-bit, 8-entry, no-bypass build
  logic [2:0]  a1_b, a2_b, a3_b, dbg_a_b;
  logic [63:0] wd3_b, rd1_b, rd2_b, dbg_rd_b;
  logic        we3_b, clr_b, busy_b;

  regfile_gen u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .a1(a1_a), .a2(a2_a), .rd1(rd1_a), .rd2(rd2_a),
    .a3(a3_a), .wd3(wd3_a), .we3(we3_a), .clr_req(clr_a),
    .dbg_a(dbg_a_a), .dbg_rd(dbg_rd_a), .busy(busy_a)
  );

  regfile_gen #(.XLEN(64), .NREGS(8), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .a1(a1_b), .a2(a2_b), .rd1(rd1_b), .rd2(rd2_b),
    .a3(a3_b), .wd3(wd3_b), .we3(we3_b), .clr_req(clr_b),
    .dbg_a(dbg_a_b), .dbg_rd(dbg_rd_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ma [32];
  logic [63:0] mb [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we3_a = 1'b0; clr_a = 1'b0;
    we3_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic zero_models();
    for (int r = 0; r < 32; r++) ma[r] = '0;
    for (int r = 0; r < 8; r++)  mb[r] = '0;
  endtask

  // Counts cycles with busy high over a fixed window, starting right now.
  task automatic count_sweep(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (busy_a === 1'b1) ca++;
      if (busy_b === 1'b1) cb++;
      tick();
    end
  endtask

  task automatic check_all_dbg(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_a_a = 5'(r);
      #1;
      check({tag, "_a"}, dbg_rd_a, (r == 0) ? 64'd0 : 64'(ma[r]));
    end
    for (int r = 0; r < 8; r++) begin
      dbg_a_b = 3'(r);
      #1;
      check({tag, "_b"}, dbg_rd_b, (r == 0) ? 64'd0 : mb[r]);
    end
    tick();
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    if (we3_a && (a3_a == addr)) return wd3_a;
    return ma[addr];
  endfunction

  function automatic logic [63:0] exp_b(input logic [2:0] addr);
    if (addr == 3'd0) return '0;
    return mb[addr];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int ca, cb, cnt;

  initial begin
    idle_inputs();
    a1_a = 5'd5; a2_a = 5'd6; a3_a = '0; wd3_a = '0; dbg_a_a = 5'd5;
    a1_b = 3'd5; a2_b = 3'd6; a3_b = '0; wd3_b = '0; dbg_a_b = 3'd5;
    rst_n = 1'b0;
    repeat (3) tick();
    #2;
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_rd1_a", rd1_a, 0);
    check("rst_rd2_a", rd2_a, 0);
    check("rst_dbg_a", dbg_rd_a, 0);
    check("rst_rd1_b", rd1_b, 0);
    tick();

    // Release: the post-reset sweep must last NREGS cycles
    rst_n = 1'b1;
    count_sweep(ca, cb);
    check("reset_sweep_len_a", 64'(ca), 32);
    check("reset_sweep_len_b", 64'(cb), 8);
    zero_models();
    check_all_dbg("reset_clear");

    // Write then read with same-cycle bypass
    a3_a = 5'd5; wd3_a = 32'hDEADBEEF; we3_a = 1'b1; a1_a = 5'd5; dbg_a_a = 5'd5;
    #2;
    check("bypass_rd1", rd1_a, 32'hDEADBEEF);
    check("dbg_no_bypass", dbg_rd_a, 0);
    tick();
    ma[5] = 32'hDEADBEEF;
    we3_a = 1'b0;
    #2;
    check("dbg_after_write", dbg_rd_a, 32'hDEADBEEF);
    check("rd1_after_write", rd1_a, 32'hDEADBEEF);
    tick();

    // Register zero stays zero
    a3_a = 5'd0; wd3_a = 32'h12345678; we3_a = 1'b1;
    a1_a = 5'd0; a2_a = 5'd0; dbg_a_a = 5'd0;
    #2;
    check("zero_rd1_wcycle", rd1_a, 0);
    check("zero_rd2_wcycle", rd2_a, 0);
    check("zero_dbg_wcycle", dbg_rd_a, 0);
    tick();
    we3_a = 1'b0;
    #2;
    check("zero_rd1_later", rd1_a, 0);
    check("zero_rd2_later", rd2_a, 0);
    check("zero_dbg_later", dbg_rd_a, 0);
    tick();

    // No-bypass build: old value in the write cycle, new value afterwards
    a3_b = 3'd3; wd3_b = 64'hFFFF_0000_FFFF_0000; we3_b = 1'b1; a1_b = 3'd3;
    #2;
    check("nobyp_old", rd1_b, 0);
    tick();
    mb[3] = 64'hFFFF_0000_FFFF_0000;
    we3_b = 1'b0;
    #2;
    check("nobyp_new", rd1_b, 64'hFFFF_0000_FFFF_0000);
    tick();

    // Randomized traffic on both builds
    for (int n = 0; n < 300; n++) begin
      a1_a = 5'($urandom); a2_a = 5'($urandom); a3_a = 5'($urandom);
      dbg_a_a = 5'($urandom); wd3_a = $urandom(); we3_a = 1'($urandom_range(0, 1));
      a1_b = 3'($urandom); a2_b = 3'($urandom); a3_b = 3'($urandom);
      dbg_a_b = 3'($urandom); wd3_b = {$urandom(), $urandom()};
      we3_b = 1'($urandom_range(0, 1));
      #2;
      check("rnd_rd1_a", rd1_a, exp_a(a1_a));
      check("rnd_rd2_a", rd2_a, exp_a(a2_a));
      check("rnd_dbg_a", dbg_rd_a, (dbg_a_a == 5'd0) ? 32'd0 : ma[dbg_a_a]);
      check("rnd_rd1_b", rd1_b, exp_b(a1_b));
      check("rnd_rd2_b", rd2_b, exp_b(a2_b));
      check("rnd_dbg_b", dbg_rd_b, exp_b(dbg_a_b));
      tick();
      if (we3_a && a3_a != 5'd0) ma[a3_a] = wd3_a;
      if (we3_b && a3_b != 3'd0) mb[a3_b] = wd3_b;
    end
    idle_inputs();

    // Fill, then clear while a write lands in the same cycle as clr_req
    for (int r = 1; r < 32; r++) begin
      a3_a = 5'(r); wd3_a = 32'hA5A5A5A5; we3_a = 1'b1;
      tick();
      ma[r] = 32'hA5A5A5A5;
    end
    a3_a = 5'd9; wd3_a = 32'h0BADF00D; we3_a = 1'b1; clr_a = 1'b1; a1_a = 5'd9;
    #2;
    check("clr_same_cycle_bypass", rd1_a, 32'h0BADF00D);
    tick();
    clr_a = 1'b0; we3_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      clr_a = (i == 5);
      if (i == 10) begin
        we3_a = 1'b1; a3_a = 5'd7; a1_a = 5'd7; a2_a = 5'd7; dbg_a_a = 5'd7;
        wd3_a = 32'hCAFEF00D;
      end else begin
        we3_a = 1'b0;
      end
      #2;
      if (i == 10) begin
        check("sweep_busy", busy_a, 1);
        check("sweep_rd1", rd1_a, 0);
        check("sweep_rd2", rd2_a, 0);
        check("sweep_dbg", dbg_rd_a, 0);
      end
      if (busy_a === 1'b1) cnt++;
      tick();
    end
    idle_inputs();
    check("clear_sweep_len", 64'(cnt), 32);
    for (int r = 0; r < 32; r++) ma[r] = '0;
    check_all_dbg("clear_sweep");

    // Reset in the middle of a sweep restarts it from the beginning
    a3_a = 5'd4; wd3_a = 32'h00000077; we3_a = 1'b1;
    tick();
    ma[4] = 32'h00000077;
    we3_a = 1'b0; clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    a1_a = 5'd4; dbg_a_a = 5'd4;
    #2;
    check("midrst_busy", busy_a, 1);
    check("midrst_rd1", rd1_a, 0);
    check("midrst_dbg", dbg_rd_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      check("midrst_hold_busy", busy_a, 1);
    end
    tick();
    rst_n = 1'b1;
    count_sweep(ca, cb);
    check("midrst_sweep_len_a", 64'(ca), 32);
    check("midrst_sweep_len_b", 64'(cb), 8);
    zero_models();
    check_all_dbg("midrst_clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
